// File: rtl/obf_key_loader_if.sv
// obf_key_loader_if: serial key handshake and committed-key bus between the loader and its driver
interface obf_key_loader_if #(parameter int KEY_BITS = 10);
  logic start, sin_valid, sin_data, sin_ready;
  logic [KEY_BITS-1:0] key_out;
  logic key_valid, busy, err;
  logic [3:0] fail_cnt;
  modport master(output start, sin_valid, sin_data, input sin_ready, key_out, key_valid, busy, err, fail_cnt);
  modport slave(input start, sin_valid, sin_data, output sin_ready, key_out, key_valid, busy, err, fail_cnt);
endinterface

// File: rtl/obf_key_loader.sv
// obf_key_loader: serial LSB-first key loader with even-parity check, atomic commit and retry lockout
module obf_key_loader #(
  parameter int KEY_BITS    = 10,
  parameter int RETRY_LIMIT = 3
) (
  input logic            clk,
  input logic            rst,
  obf_key_loader_if.slave bus
);
  localparam int CW = $clog2(KEY_BITS);
  typedef enum logic [2:0] {IDLE, LOAD, PARITY, ERROR, LOCKED, DEAD} state_t;
  state_t              state_q;
  logic [KEY_BITS-1:0] shadow_q, key_q;
  logic [CW-1:0]       cnt_q;
  logic                key_valid_q, err_q;
  logic [3:0]          fail_cnt_q, fail_cnt_d;
  logic                parity_ok;
  assign fail_cnt_d    = fail_cnt_q + 4'd1;
  assign parity_ok     = ~(^shadow_q ^ bus.sin_data);
  assign bus.sin_ready = (state_q == LOAD) || (state_q == PARITY);
  assign bus.busy      = bus.sin_ready;
  assign bus.key_out   = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.err       = err_q;
  assign bus.fail_cnt  = fail_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      cnt_q       <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      fail_cnt_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE, ERROR: if (bus.start) begin
          shadow_q <= '0;
          cnt_q    <= '0;
          err_q    <= 1'b0;
          state_q  <= LOAD;
        end
        LOAD: if (bus.start) begin
          shadow_q <= '0;
          cnt_q    <= '0;
        end else if (bus.sin_valid) begin
          shadow_q[cnt_q] <= bus.sin_data;
          cnt_q           <= cnt_q + 1'b1;
          if (cnt_q == CW'(KEY_BITS - 1)) state_q <= PARITY;
        end
        PARITY: if (bus.start) begin
          shadow_q <= '0;
          cnt_q    <= '0;
          state_q  <= LOAD;
        end else if (bus.sin_valid && parity_ok) begin
          key_q       <= shadow_q;
          key_valid_q <= 1'b1;
          err_q       <= 1'b0;
          state_q     <= LOCKED;
        end else if (bus.sin_valid) begin
          err_q      <= 1'b1;
          fail_cnt_q <= fail_cnt_d;
          // lockout also scrubs any key so a dead loader never drives a usable key
          if (fail_cnt_d == 4'(RETRY_LIMIT)) begin
            key_q       <= '0;
            key_valid_q <= 1'b0;
            state_q     <= DEAD;
          end else state_q <= ERROR;
        end
        LOCKED, DEAD: ;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_obf_key_loader.sv
// tb_obf_key_loader: directed scenario tests for the serial key loader
module tb_obf_key_loader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int passed = 0;
  obf_key_loader_if #(.KEY_BITS(10)) bus();
  obf_key_loader #(.KEY_BITS(10), .RETRY_LIMIT(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps && $urandom_range(0, 1) == 1) begin
      bus.sin_valid = 1'b0;
      bus.sin_data  = ~b;
      tick();
    end
    bus.sin_valid = 1'b1;
    bus.sin_data  = b;
    tick();
    bus.sin_valid = 1'b0;
    bus.sin_data  = 1'b0;
  endtask

  task automatic send_key(input logic [9:0] k, input logic p, input bit gaps);
    for (int i = 0; i < 10; i++) send_bit(k[i], gaps);
    send_bit(p, gaps);
  endtask

  task automatic test_reset();
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.key_out !== 10'h000) $display("FAIL t1_key_out got %h exp 000", bus.key_out); else passed++;
    checks++; if (bus.key_valid !== 1'b0) $display("FAIL t1_key_valid got %b exp 0", bus.key_valid); else passed++;
    checks++; if (bus.err !== 1'b0) $display("FAIL t1_err got %b exp 0", bus.err); else passed++;
    checks++; if (bus.sin_ready !== 1'b0) $display("FAIL t1_sin_ready got %b exp 0", bus.sin_ready); else passed++;
    checks++; if (bus.fail_cnt !== 4'd0) $display("FAIL t1_fail_cnt got %0d exp 0", bus.fail_cnt); else passed++;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) $display("FAIL t1_idle_busy got %b exp 0", bus.busy); else passed++;
  endtask

  task automatic test_good_load();
    do_reset();
    do_start();
    checks++; if (bus.sin_ready !== 1'b1) $display("FAIL t2_ready_load got %b exp 1", bus.sin_ready); else passed++;
    for (int i = 0; i < 10; i++) send_bit((i == 1) ? 1'b1 : 1'b0, 1'b0);
    checks++; if ({bus.busy, bus.key_valid, bus.key_out} !== {1'b1, 1'b0, 10'h000}) $display("FAIL t2_pre_parity got busy=%b kv=%b key=%h exp busy=1 kv=0 key=000", bus.busy, bus.key_valid, bus.key_out); else passed++;
    send_bit(1'b1, 1'b0);
    checks++; if (bus.key_out !== 10'h002) $display("FAIL t2_key_out got %h exp 002", bus.key_out); else passed++;
    checks++; if (bus.key_valid !== 1'b1) $display("FAIL t2_key_valid got %b exp 1", bus.key_valid); else passed++;
    checks++; if ({bus.sin_ready, bus.busy, bus.err} !== 3'b000) $display("FAIL t2_locked got ready/busy/err=%b exp 000", {bus.sin_ready, bus.busy, bus.err}); else passed++;
    do_start();
    for (int i = 0; i < 20; i++) send_bit(i[0], 1'b0);
    checks++; if ({bus.key_valid, bus.key_out} !== {1'b1, 10'h002}) $display("FAIL t6_locked_key got kv=%b key=%h exp kv=1 key=002", bus.key_valid, bus.key_out); else passed++;
    checks++; if (bus.sin_ready !== 1'b0) $display("FAIL t6_locked_ready got %b exp 0", bus.sin_ready); else passed++;
  endtask

  task automatic test_bad_parity();
    do_reset();
    do_start();
    send_key(10'b0000000001, 1'b0, 1'b0);
    checks++; if (bus.err !== 1'b1) $display("FAIL t3_err got %b exp 1", bus.err); else passed++;
    checks++; if (bus.fail_cnt !== 4'd1) $display("FAIL t3_fail_cnt got %0d exp 1", bus.fail_cnt); else passed++;
    checks++; if ({bus.key_valid, bus.key_out} !== {1'b0, 10'h000}) $display("FAIL t3_no_commit got kv=%b key=%h exp kv=0 key=000", bus.key_valid, bus.key_out); else passed++;
    checks++; if (bus.sin_ready !== 1'b0) $display("FAIL t3_ready got %b exp 0", bus.sin_ready); else passed++;
    do_start();
    checks++; if ({bus.err, bus.sin_ready} !== 2'b01) $display("FAIL t3_retry got err/ready=%b exp 01", {bus.err, bus.sin_ready}); else passed++;
    send_key(10'b0000000010, 1'b1, 1'b0);
    checks++; if ({bus.err, bus.key_valid, bus.key_out} !== {1'b0, 1'b1, 10'h002}) $display("FAIL t3_recover got err=%b kv=%b key=%h exp err=0 kv=1 key=002", bus.err, bus.key_valid, bus.key_out); else passed++;
    checks++; if (bus.fail_cnt !== 4'd1) $display("FAIL t3_fail_cnt_hold got %0d exp 1", bus.fail_cnt); else passed++;
  endtask

  task automatic test_lockout();
    do_reset();
    for (int n = 1; n <= 3; n++) begin
      do_start();
      send_key(10'b1100000111, 1'b0, 1'b0);
      checks++; if ({bus.err, bus.fail_cnt} !== {1'b1, 4'(n)}) $display("FAIL t4_fail_%0d got err=%b cnt=%0d exp err=1 cnt=%0d", n, bus.err, bus.fail_cnt, n); else passed++;
    end
    checks++; if ({bus.key_valid, bus.key_out} !== {1'b0, 10'h000}) $display("FAIL t4_dead_key got kv=%b key=%h exp kv=0 key=000", bus.key_valid, bus.key_out); else passed++;
    do_start();
    checks++; if ({bus.sin_ready, bus.busy} !== 2'b00) $display("FAIL t4_dead_start got ready/busy=%b exp 00", {bus.sin_ready, bus.busy}); else passed++;
    send_key(10'b0000000010, 1'b1, 1'b0);
    checks++; if ({bus.err, bus.fail_cnt, bus.key_valid} !== {1'b1, 4'd3, 1'b0}) $display("FAIL t4_dead_hold got err=%b cnt=%0d kv=%b exp err=1 cnt=3 kv=0", bus.err, bus.fail_cnt, bus.key_valid); else passed++;
  endtask

  task automatic test_restart_gaps();
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
    bus.start     = 1'b1;
    bus.sin_valid = 1'b1;
    bus.sin_data  = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.sin_valid = 1'b0;
    send_key(10'b0000000010, 1'b1, 1'b1);
    checks++; if ({bus.key_valid, bus.key_out} !== {1'b1, 10'h002}) $display("FAIL t5_restart_load got kv=%b key=%h exp kv=1 key=002", bus.key_valid, bus.key_out); else passed++;
    do_reset();
    do_start();
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    do_start();
    checks++; if ({bus.sin_ready, bus.busy, bus.err} !== 3'b110) $display("FAIL t5_parity_restart got ready/busy/err=%b exp 110", {bus.sin_ready, bus.busy, bus.err}); else passed++;
    send_key(10'b1010000001, 1'b1, 1'b1);
    checks++; if ({bus.key_valid, bus.key_out} !== {1'b1, 10'b1010000001}) $display("FAIL t5_parity_restart_key got kv=%b key=%h exp kv=1 key=281", bus.key_valid, bus.key_out); else passed++;
  endtask

  task automatic test_reset_midload();
    do_reset();
    do_start();
    send_key(10'b0000000000, 1'b1, 1'b0);
    do_start();
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
    checks++; if ({bus.busy, bus.fail_cnt} !== {1'b1, 4'd1}) $display("FAIL t6_midload got busy=%b cnt=%0d exp busy=1 cnt=1", bus.busy, bus.fail_cnt); else passed++;
    #3;
    rst = 1'b1;
    #1;
    checks++; if ({bus.key_out, bus.key_valid, bus.err, bus.sin_ready, bus.busy, bus.fail_cnt} !== 18'd0) $display("FAIL t6_rst_outputs got key=%h kv=%b err=%b ready=%b busy=%b cnt=%0d exp all 0", bus.key_out, bus.key_valid, bus.err, bus.sin_ready, bus.busy, bus.fail_cnt); else passed++;
    tick();
    rst = 1'b0;
    send_bit(1'b1, 1'b0);
    checks++; if (bus.sin_ready !== 1'b0) $display("FAIL t6_idle_after_rst got ready=%b exp 0", bus.sin_ready); else passed++;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sin_data  = 1'b0;
    test_reset();
    test_good_load();
    test_bad_parity();
    test_lockout();
    test_restart_gaps();
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
